ram_frame_writer: RTL and testbench

// - Write-side counterpart to the team's registered-read ROM/RAM blocks.
// - Accepts a stream of blockLength-bit words on a valid/ready handshake.
// - Writes them sequentially into a block RAM write port (addresses 0..memDepth-1), one frame per start pulse.
// - Signals completion so the consumer can then read the RAM through its enable/address port.

---
 rtl/ram_frame_writer.sv | 112 +++++++++++
 tb/tb_ram_frame_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_frame_writer.sv
// Streams one frame of words per start pulse into a RAM write port at addresses 0..memDepth-1.
// Optional running checksum of accepted words is enabled with RAM_FRAME_WRITER_CHECKSUM_EN.
module ram_frame_writer #(
  parameter int blockLength     = 12,
  parameter int memDepth        = 100,
  parameter int addressBitWidth = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [blockLength-1:0]     dataIn,
  input  logic                       dataValid,
  output logic                       dataReady,
  output logic                       wrEnable,
  output logic [addressBitWidth-1:0] wrAddress,
  output logic [blockLength-1:0]     wrData,
  output logic                       busy,
  output logic                       done,
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
  output logic [blockLength-1:0]     checksum,
`endif
  output logic [1:0]                 stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [addressBitWidth-1:0] LAST_ADDR = addressBitWidth'(memDepth - 1);

  state_t                       state_q, state_d;
  logic [addressBitWidth-1:0]   cnt_q, cnt_d;
  logic                         wr_en_q, wr_en_d;
  logic [addressBitWidth-1:0]   wr_addr_q, wr_addr_d;
  logic [blockLength-1:0]       wr_data_q, wr_data_d;
  logic [blockLength-1:0]       sum_q, sum_d;
  logic                         accept;

  // Valid/ready: a word transfers on a rising edge where dataValid && dataReady;
  // dataReady is decoded from state only, and a same-cycle abort cancels the transfer.
  assign accept = (state_q == LOAD) && dataValid && !abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sum_q     <= sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sum_d     = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = dataIn;
          sum_d     = sum_q + dataIn;
          // Counter stops at the last address so it never wraps inside a frame.
          if (cnt_q == LAST_ADDR) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dataReady = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign wrEnable  = wr_en_q;
  assign wrAddress = wr_addr_q;
  assign wrData    = wr_data_q;
  assign stateDbg  = state_q;

`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
  assign checksum = sum_q;
`else
  logic unused_sum;
  assign unused_sum = ^sum_q;
`endif

endmodule

// File: tb/tb_ram_frame_writer.sv
// Directed bench for ram_frame_writer (memDepth=4): expected writes are queued by the stimulus
// and popped by a negedge monitor whenever the DUT strobes wrEnable.
module tb_ram_frame_writer;

  localparam int BL = 12;
  localparam int AW = 7;
  localparam int W  = 1 + AW + BL;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BL-1:0] dataIn = '0;
  logic          dataValid = 1'b0;
  logic          dataReady, wrEnable, busy, done;
  logic [AW-1:0] wrAddress;
  logic [BL-1:0] wrData;
  logic [1:0]    stateDbg;
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
  logic [BL-1:0] checksum;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  ram_frame_writer #(.blockLength(BL), .memDepth(4), .addressBitWidth(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .wrEnable(wrEnable), .wrAddress(wrAddress), .wrData(wrData),
    .busy(busy), .done(done),
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .stateDbg(stateDbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc(input logic v, input logic [BL-1:0] d, input logic s, input logic a);
    dataValid = v; dataIn = d; start = s; abort = a;
    @(posedge clock); #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [BL-1:0] d, input logic last);
    exp_q.push_back({last, a, d});
  endtask

  task automatic word(input logic [AW-1:0] a, input logic [BL-1:0] d, input logic last);
    expect_write(a, d, last);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (wrEnable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h done=%b exp none", wrAddress, wrData, done);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({done, wrAddress, wrData} !== e) begin
          errors++;
          $display("FAIL write got done=%b addr=%h data=%h exp done=%b addr=%h data=%h",
                   done, wrAddress, wrData, e[W-1], e[W-2:BL], e[BL-1:0]);
        end
      end
    end else if (done) begin
      checks++;
      errors++;
      $display("FAIL done_without_write got done=1 wrEnable=0 exp done=0");
    end
  end

  initial begin
    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", dataReady, 0);
    check("rst_wren", wrEnable, 0);
    check("rst_addr", wrAddress, 0);
    check("rst_data", wrData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", stateDbg, 0);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    check("rst_sum", checksum, 0);
`endif
    reset = 1'b0;
    idle_cyc();

    // 1: back-to-back frame
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("t1_ready", dataReady, 1);
    check("t1_busy", busy, 1);
    word(0, 12'h001, 0);
    check("t1_latency_wren", wrEnable, 1);
    check("t1_latency_addr", wrAddress, 0);
    word(1, 12'h002, 0);
    word(2, 12'h003, 0);
    word(3, 12'h004, 1);
    check("t1_done", done, 1);
    check("t1_ready_after_last", dataReady, 0);
    cyc(1'b1, 12'h005, 1'b0, 1'b0);
    check("t1_done_one_cycle", done, 0);
    check("t1_no_extra_write", wrEnable, 0);
    check("t1_addr_hold", wrAddress, 3);
    check("t1_data_hold", wrData, 12'h004);
    idle_cyc();

    // 2: dataValid toggling
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(0, 12'h010, 0);
    cyc(1'b0, 12'h0AA, 1'b0, 1'b0);
    check("t2_gap_wren", wrEnable, 0);
    word(1, 12'h011, 0);
    cyc(1'b0, 12'h0BB, 1'b0, 1'b0);
    word(2, 12'h012, 0);
    cyc(1'b0, 12'h0CC, 1'b0, 1'b0);
    check("t2_stall_busy", busy, 1);
    word(3, 12'h013, 1);
    check("t2_done", done, 1);
    idle_cyc();

    // 3: abort with a same-cycle valid word
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(0, 12'h021, 0);
    word(1, 12'h022, 0);
    cyc(1'b1, 12'h023, 1'b0, 1'b1);
    check("t3_abort_busy", busy, 0);
    check("t3_abort_ready", dataReady, 0);
    check("t3_abort_done", done, 0);
    check("t3_abort_state", stateDbg, 0);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    check("t3_partial_sum", checksum, 12'h043);
`endif
    idle_cyc();
    check("t3_no_done", done, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(0, 12'h031, 0);
    word(1, 12'h032, 0);
    word(2, 12'h033, 0);
    word(3, 12'h034, 1);
    idle_cyc();

    // 4: start held during LOAD and in the DONE cycle
    cyc(1'b0, '0, 1'b1, 1'b0);
    expect_write(0, 12'h041, 0); cyc(1'b1, 12'h041, 1'b1, 1'b0);
    expect_write(1, 12'h042, 0); cyc(1'b1, 12'h042, 1'b1, 1'b0);
    expect_write(2, 12'h043, 0); cyc(1'b1, 12'h043, 1'b1, 1'b0);
    expect_write(3, 12'h044, 1); cyc(1'b1, 12'h044, 1'b1, 1'b0);
    check("t4_done", done, 1);
    cyc(1'b1, 12'h045, 1'b1, 1'b0);
    check("t4_start_in_done_ignored", busy, 0);
    cyc(1'b1, 12'h046, 1'b0, 1'b0);
    check("t4_idle_no_accept", wrEnable, 0);
    check("t4_idle_busy", busy, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(0, 12'h047, 0);
    word(1, 12'h048, 0);
    word(2, 12'h049, 0);
    word(3, 12'h04A, 1);
    idle_cyc();

    // 5: reset mid-frame
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(0, 12'h051, 0);
    word(1, 12'h052, 0);
    reset = 1'b1;
    cyc(1'b1, 12'h053, 1'b0, 1'b0);
    check("t5_wren", wrEnable, 0);
    check("t5_addr", wrAddress, 0);
    check("t5_data", wrData, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", dataReady, 0);
    check("t5_done", done, 0);
    reset = 1'b0;
    cyc(1'b1, 12'h053, 1'b0, 1'b0);
    cyc(1'b1, 12'h054, 1'b0, 1'b0);
    check("t5_stalled", wrEnable, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    word(0, 12'h055, 0);
    word(1, 12'h056, 0);
    word(2, 12'h057, 0);
    word(3, 12'h058, 1);
    idle_cyc();

    // 6: checksum wrap
    cyc(1'b0, '0, 1'b1, 1'b0);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    check("t6_sum_cleared", checksum, 0);
`endif
    word(0, 12'hFFF, 0);
    word(1, 12'h002, 0);
    word(2, 12'h003, 0);
    word(3, 12'h004, 1);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    check("t6_sum_at_done", checksum, 12'h008);
`endif
    idle_cyc();
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    check("t6_sum_hold", checksum, 12'h008);
`endif
    idle_cyc();

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
